sram_arbiter: RTL and testbench

Shares the single 8-bit SRAM bus between two requesters: the AVR side (address from an internal auto-incrementing counter) and the SNES cart side (direct address).
Grants one fixed-timing SRAM cycle at a time and generates sram_ce_n/oe_n/we_n, the address and the write-data enable.
Sits between the AVR bus logic / SNES cart interface and the SRAM pins inside system.

---
 rtl/qd_sram_pkg.sv | 21 ++
 rtl/sram_addr_counter.sv | 29 ++
 rtl/sram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/qd_sram_pkg.sv
// Shared types for the SRAM arbiter slice.
//   state_t : arbiter bus-cycle phases
//   gnt_t   : which requester owns the current SRAM cycle
package qd_sram_pkg;

    localparam int unsigned ADDR_W_DEF = 21;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_AVR  = 1'b0,
        GNT_SNES = 1'b1
    } gnt_t;

endpackage

// File: rtl/sram_addr_counter.sv
// AVR-side SRAM address counter: synchronous load, post-increment, wraps at 2^ADDR_W.
//   clk, reset : clock, async active-high reset
//   load       : load count from load_val (wins over inc)
//   inc        : increment count by one
//   count      : current counter value (registered)
module sram_addr_counter
    import qd_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM bus arbiter (AVR counter-addressed, SNES direct-addressed).
// Runs one fixed-timing IDLE/SETUP/ACCESS/DONE cycle per grant, round-robin on ties.
//   avr_*  : AVR request/ack/data plus address counter controls
//   snes_* : SNES request/ack/data with direct address
//   sram_* : registered SRAM address, write data, drive enable and active-low strobes
module sram_arbiter
    import qd_sram_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avr_load,
    input  logic [ADDR_W-1:0] avr_addr,
    input  logic              avr_inc,
    input  logic              avr_req,
    input  logic              avr_we,
    input  logic [DATA_W-1:0] avr_wdata,
    output logic [DATA_W-1:0] avr_rdata,
    output logic              avr_ack,
    output logic [ADDR_W-1:0] avr_cur_addr,
    input  logic              snes_req,
    input  logic              snes_we,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [DATA_W-1:0] snes_wdata,
    output logic [DATA_W-1:0] snes_rdata,
    output logic              snes_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned WAIT_W   = $clog2(MAX_WAIT) + 1;

    state_t            state;
    state_t            next_state;
    gnt_t              lat_gnt;
    gnt_t              last_grant;
    logic              lat_we;
    logic              any_req;
    logic              pick_snes;
    logic              wait_last;
    logic              cyc_we;
    logic              cnt_inc;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ce_n_nxt;
    logic              oe_n_nxt;
    logic              we_n_nxt;
    logic              dout_en_nxt;
    logic              avr_ack_nxt;
    logic              snes_ack_nxt;

    // Tie goes to whoever was not served last
    assign any_req   = avr_req | snes_req;
    assign pick_snes = snes_req & (~avr_req | (last_grant == GNT_AVR));
    assign wait_last = (wait_cnt == WAIT_W'((lat_we ? WR_WAIT : RD_WAIT) - 1));
    assign cnt_inc   = (state == DONE) && (lat_gnt == GNT_AVR) && avr_inc;

    sram_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (avr_load),
        .load_val (avr_addr),
        .inc      (cnt_inc),
        .count    (avr_cur_addr)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (wait_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: values the strobes/acks take in next_state, registered below
    always_comb begin
        ce_n_nxt     = 1'b1;
        oe_n_nxt     = 1'b1;
        we_n_nxt     = 1'b1;
        dout_en_nxt  = 1'b0;
        avr_ack_nxt  = 1'b0;
        snes_ack_nxt = 1'b0;
        // Direction of the cycle being entered: fresh at grant, latched afterwards
        cyc_we = (state == IDLE) ? (pick_snes ? snes_we : avr_we) : lat_we;
        case (next_state)
            SETUP: begin
                ce_n_nxt    = 1'b0;
                dout_en_nxt = cyc_we;
            end
            ACCESS: begin
                ce_n_nxt    = 1'b0;
                dout_en_nxt = cyc_we;
                oe_n_nxt    = cyc_we;
                we_n_nxt    = ~cyc_we;
            end
            DONE: begin
                ce_n_nxt     = 1'b0;
                dout_en_nxt  = cyc_we;
                avr_ack_nxt  = (lat_gnt == GNT_AVR);
                snes_ack_nxt = (lat_gnt == GNT_SNES);
            end
            default: ;
        endcase
    end

    // Output registers, grant latch, wait counter and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_dout_en <= 1'b0;
            avr_ack      <= 1'b0;
            snes_ack     <= 1'b0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            avr_rdata    <= '0;
            snes_rdata   <= '0;
            lat_gnt      <= GNT_AVR;
            last_grant   <= GNT_AVR;
            lat_we       <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            sram_ce_n    <= ce_n_nxt;
            sram_oe_n    <= oe_n_nxt;
            sram_we_n    <= we_n_nxt;
            sram_dout_en <= dout_en_nxt;
            avr_ack      <= avr_ack_nxt;
            snes_ack     <= snes_ack_nxt;
            wait_cnt     <= (state == ACCESS) ? wait_cnt + WAIT_W'(1) : '0;

            if (state == IDLE && any_req) begin
                lat_gnt    <= pick_snes ? GNT_SNES : GNT_AVR;
                last_grant <= pick_snes ? GNT_SNES : GNT_AVR;
                lat_we     <= cyc_we;
                sram_addr  <= pick_snes ? snes_addr : avr_cur_addr;
                sram_dout  <= pick_snes ? snes_wdata : avr_wdata;
            end

            if (state == ACCESS && wait_last && !lat_we) begin
                if (lat_gnt == GNT_SNES) begin
                    snes_rdata <= sram_din;
                end else begin
                    avr_rdata <= sram_din;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (RD_WAIT = WR_WAIT = 2).
module tb_sram_arbiter;
    import qd_sram_pkg::*;

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          avr_load, avr_inc, avr_req, avr_we;
    logic [AW-1:0] avr_addr;
    logic [DW-1:0] avr_wdata, avr_rdata;
    logic          avr_ack;
    logic [AW-1:0] avr_cur_addr;
    logic          snes_req, snes_we, snes_ack;
    logic [AW-1:0] snes_addr;
    logic [DW-1:0] snes_wdata, snes_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout, sram_din;
    logic          sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

    logic [DW-1:0] din_v;
    logic          din_mode;

    int checks   = 0;
    int failures = 0;

    // Per-access observations, bit i = value in cycle i+1 after the grant edge
    logic [4:0]    ce_p, oe_p, we_p, den_p, ack_p, oth_p;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] dout_s;

    always #5 clk = ~clk;

    // Simple SRAM read model: fixed byte, or address-keyed in the tie test
    assign sram_din = din_mode ? ((sram_addr == snes_addr) ? 8'h22 : 8'hBB) : din_v;

    sram_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .RD_WAIT (2), .WR_WAIT (2)
    ) dut (
        .clk (clk), .reset (reset),
        .avr_load (avr_load), .avr_addr (avr_addr), .avr_inc (avr_inc),
        .avr_req (avr_req), .avr_we (avr_we), .avr_wdata (avr_wdata),
        .avr_rdata (avr_rdata), .avr_ack (avr_ack), .avr_cur_addr (avr_cur_addr),
        .snes_req (snes_req), .snes_we (snes_we), .snes_addr (snes_addr),
        .snes_wdata (snes_wdata), .snes_rdata (snes_rdata), .snes_ack (snes_ack),
        .sram_addr (sram_addr), .sram_dout (sram_dout), .sram_dout_en (sram_dout_en),
        .sram_din (sram_din), .sram_ce_n (sram_ce_n), .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One access by a single requester; req dropped after its ack is seen,
    // optional counter load placed on the edge that ends DONE.
    task automatic do_access(input logic snes, input logic we, input logic [DW-1:0] wd,
                             input logic load_done, input logic [AW-1:0] load_val);
        logic seen;
        seen = 1'b0;
        if (snes) begin
            snes_req = 1'b1; snes_we = we; snes_wdata = wd;
        end else begin
            avr_req = 1'b1; avr_we = we; avr_wdata = wd;
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            avr_load = 1'b0;
            ce_p[i]  = sram_ce_n;
            oe_p[i]  = sram_oe_n;
            we_p[i]  = sram_we_n;
            den_p[i] = sram_dout_en;
            ack_p[i] = snes ? snes_ack : avr_ack;
            oth_p[i] = snes ? avr_ack : snes_ack;
            if (i == 0) begin
                addr_s = sram_addr;
                // Post-grant changes must not affect the running cycle
                if (snes) begin
                    snes_we = ~we; snes_wdata = ~wd;
                end else begin
                    avr_we = ~we; avr_wdata = ~wd;
                end
            end
            if (i == 3) dout_s = sram_dout;
            if (ack_p[i] && !seen) begin
                seen = 1'b1;
                if (snes) snes_req = 1'b0; else avr_req = 1'b0;
                if (load_done) begin
                    avr_load = 1'b1; avr_addr = load_val;
                end
            end
        end
        if (snes) snes_req = 1'b0; else avr_req = 1'b0;
    endtask

    task automatic check_pats(input string t, input logic we);
        check_eq({t, "_ce"},  32'(ce_p),  32'b10000);
        check_eq({t, "_oe"},  32'(oe_p),  we ? 32'b11111 : 32'b11001);
        check_eq({t, "_we"},  32'(we_p),  we ? 32'b11001 : 32'b11111);
        check_eq({t, "_den"}, 32'(den_p), we ? 32'b01111 : 32'b00000);
        check_eq({t, "_ack"}, 32'(ack_p), 32'b01000);
        check_eq({t, "_oth"}, 32'(oth_p), 32'b00000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq;
        int         n;
        logic       dual;

        reset = 1'b1;
        avr_load = 0; avr_addr = '0; avr_inc = 0; avr_req = 0; avr_we = 0; avr_wdata = '0;
        snes_req = 0; snes_we = 0; snes_addr = '0; snes_wdata = '0;
        din_v = '0; din_mode = 0;
        tick; tick;

        // 1. Reset values
        check_eq("rst_ce",   32'(sram_ce_n), 32'd1);
        check_eq("rst_oe",   32'(sram_oe_n), 32'd1);
        check_eq("rst_we",   32'(sram_we_n), 32'd1);
        check_eq("rst_den",  32'(sram_dout_en), 32'd0);
        check_eq("rst_acks", 32'({avr_ack, snes_ack}), 32'd0);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_cur",  32'(avr_cur_addr), 32'd0);
        check_eq("rst_rd",   32'({avr_rdata, snes_rdata}), 32'd0);
        reset = 1'b0;

        // 1b. Reset asserted mid-ACCESS
        avr_req = 1'b1; avr_we = 1'b0;
        tick; tick;
        check_eq("mr_pre_oe", 32'(sram_oe_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("mr_ce", 32'(sram_ce_n), 32'd1);
        check_eq("mr_oe", 32'(sram_oe_n), 32'd1);
        avr_req = 1'b0;
        tick;
        check_eq("mr_ack", 32'({avr_ack, snes_ack}), 32'd0);
        tick;
        check_eq("mr_ack2", 32'({avr_ack, snes_ack}), 32'd0);
        reset = 1'b0;

        // 2. AVR read at loaded counter address
        avr_load = 1'b1; avr_addr = 21'h1F0F3;
        tick;
        avr_load = 1'b0;
        avr_inc = 1'b1; din_v = 8'hAA;
        do_access(1'b0, 1'b0, 8'h00, 1'b0, '0);
        check_pats("t2", 1'b0);
        check_eq("t2_addr",  32'(addr_s), 32'h1F0F3);
        check_eq("t2_rdata", 32'(avr_rdata), 32'hAA);
        check_eq("t2_cur",   32'(avr_cur_addr), 32'h1F0F4);

        // 3. SNES write
        snes_addr = 21'h000123;
        do_access(1'b1, 1'b1, 8'hEE, 1'b0, '0);
        check_pats("t3", 1'b1);
        check_eq("t3_addr",  32'(addr_s), 32'h123);
        check_eq("t3_dout",  32'(dout_s), 32'hEE);
        check_eq("t3_srd",   32'(snes_rdata), 32'h00);
        check_eq("t3_ard",   32'(avr_rdata), 32'hAA);
        check_eq("t3_cur",   32'(avr_cur_addr), 32'h1F0F4);

        // 5. Counter wrap, then load beating the DONE increment
        avr_load = 1'b1; avr_addr = 21'h1FFFFF;
        tick;
        avr_load = 1'b0;
        do_access(1'b0, 1'b0, 8'h00, 1'b0, '0);
        check_eq("t5_addr", 32'(addr_s), 32'h1FFFFF);
        check_eq("t5_wrap", 32'(avr_cur_addr), 32'h0);
        do_access(1'b0, 1'b0, 8'h00, 1'b1, 21'h00055);
        check_eq("t5_load", 32'(avr_cur_addr), 32'h55);

        // 6. AVR write then immediate read at the incremented address
        avr_load = 1'b1; avr_addr = 21'h00100;
        tick;
        avr_load = 1'b0;
        do_access(1'b0, 1'b1, 8'hEE, 1'b0, '0);
        check_pats("t6w", 1'b1);
        check_eq("t6w_addr", 32'(addr_s), 32'h100);
        check_eq("t6w_dout", 32'(dout_s), 32'hEE);
        din_v = 8'h5A;
        do_access(1'b0, 1'b0, 8'h00, 1'b0, '0);
        check_pats("t6r", 1'b0);
        check_eq("t6r_addr",  32'(addr_s), 32'h101);
        check_eq("t6r_rdata", 32'(avr_rdata), 32'h5A);

        // 4. Both requesting from reset: round-robin starting with SNES
        reset = 1'b1;
        avr_inc = 1'b0;
        tick;
        reset = 1'b0;
        din_mode = 1'b1; snes_addr = 21'h10;
        avr_we = 1'b0; snes_we = 1'b0;
        avr_req = 1'b1; snes_req = 1'b1;
        seq = '0; n = 0; dual = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick;
            if (avr_ack && snes_ack) dual = 1'b1;
            if (snes_ack) begin
                seq[n] = 1'b1; n++;
            end else if (avr_ack) begin
                seq[n] = 1'b0; n++;
            end
        end
        avr_req = 1'b0; snes_req = 1'b0;
        tick; tick;
        check_eq("t4_count", 32'(n), 32'd4);
        check_eq("t4_order", 32'(seq), 32'b0101);
        check_eq("t4_dual",  32'(dual), 32'd0);
        check_eq("t4_srd",   32'(snes_rdata), 32'h22);
        check_eq("t4_ard",   32'(avr_rdata), 32'hBB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
